mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Two-client arbiter between the instruction cache (client 0) and the data cache (client 1), downstream of both, driving the single shared 128-bit block memory port.
- Uses the same level handshake the caches already speak: mem_read/mem_write held high until mem_ready.
- Serialises the two clients with round-robin priority, exactly one outstanding memory transaction at a time.

Parameters:
- ADDR_W, 28, block address width (word address >> 2).
- DATA_W, 128, block width in bits.
- TIMEOUT, 255, watchdog limit in cycles; used only with MEM_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- c0_read  in  1  client 0 read request (level).
- c0_write  in  1  client 0 write request (level).
- c0_addr  in  ADDR_W  client 0 block address.
- c0_wdata  in  DATA_W  client 0 write block.
- c0_rdata  out  DATA_W  read data to client 0.
- c0_ready  out  1  completion to client 0.
- c1_read, c1_write, c1_addr, c1_wdata, c1_rdata, c1_ready: same set for client 1.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- mem_addr  out  ADDR_W  memory block address.
- mem_wdata  out  DATA_W  memory write block.
- mem_rdata  in  DATA_W  memory read block.
- mem_ready  in  1  memory completion, one-cycle pulse.
- arb_err  out  1  timeout pulse; tied 0 without the macro.

Behaviour:
- Reset: async on rst_n low.
  - Clears state to IDLE and rr_ptr to 0 (client 0 preferred).
  - Clears mem_read, mem_write, mem_addr, mem_wdata, arb_err, and c0_ready/c1_ready.
  - Reset mid-transaction abandons the request; memory sees mem_read/mem_write drop immediately.
- FSM states: IDLE, ISSUE, DONE.
- IDLE:
  - reqN = cN_read | cN_write.
  - If both requests are high, grant client rr_ptr; otherwise grant the single requester.
  - On grant, latch grant id, op, cN_addr and cN_wdata into output registers; the next state is ISSUE.
  - Latency: request high in cycle N gives mem_read/mem_write high from cycle N+1.
- ISSUE:
  - mem_read/mem_write are held from registers; address and data are stable.
  - On mem_ready: drop mem_read/mem_write in the next cycle, toggle rr_ptr to the non-granted client, and go to DONE.
- DONE:
  - Lasts exactly one cycle; all requests are ignored, then the block returns to IDLE.
  - Reason: the caches sample mem_ready through a register and keep their request high one cycle after ready. DONE absorbs that stale request.
- Response paths:
  - cN_ready = mem_ready & (state==ISSUE) & (grant==N); combinational.
  - c0_rdata = c1_rdata = mem_rdata, broadcast unregistered.
- cN_read & cN_write together is illegal. The write is serviced and the read is dropped.
- A request that drops while in ISSUE does not cancel the memory transaction; it completes and ready is still pulsed.
- A non-granted client must hold its request until its own ready pulse; no request queue beyond the one latched request.
- mem_ready outside ISSUE is ignored.

Optional Feature:
- Macro: MEM_ARB_TIMEOUT_EN.
- Enabled:
  - An 8-bit-minimum counter ($clog2(TIMEOUT+1)) starts at 0 on entry to ISSUE and increments each ISSUE cycle.
  - On reaching TIMEOUT without mem_ready: arb_err pulses for one cycle, mem_read/mem_write drop, no cN_ready is pulsed, rr_ptr toggles, and the FSM goes to DONE.
- Disabled: no counter; arb_err is constant 0; ISSUE waits indefinitely.

Decomposition:
- Package mem_arb_pkg: state encoding (IDLE=0, ISSUE=1, DONE=2, 2 bits), OP_READ/OP_WRITE constants, default ADDR_W/DATA_W.
- One sub-module, rr_arb2: combinational 2-way round-robin select (req[1:0], rr_ptr) -> grant id, valid.
- The rr_ptr register stays in mem_arbiter.

Test Plan:
- Single read:
  - c0_read=1, c0_addr=0x0000010 at cycle 1 -> mem_read=1, mem_addr=0x0000010 from cycle 2.
  - Memory returns mem_rdata=0xDEADBEEF_...; mem_ready pulses at cycle 6 -> c0_ready=1 and c0_rdata equal that value at cycle 6.
  - mem_read=0 at cycle 7.
- Contention:
  - c0_read and c1_write (c1_addr=0x0000020, c1_wdata=0x1111...) asserted together after reset -> client 0 served first.
  - After DONE, mem_write=1 with mem_addr=0x0000020 and mem_wdata=0x1111...; the next tie is granted to client 0 again only after client 1 has been served.
- Stale request:
  - Client 1 keeps c1_read high one cycle after c1_ready -> no second mem_read issued for it during DONE.
  - Next grant starts no earlier than 2 cycles after mem_ready.
- Illegal op: c0_read=c0_write=1 -> mem_write=1, mem_read=0.
- Reset mid-ISSUE: rst_n low while mem_read=1 -> mem_read=0 immediately (asynchronous); after release, state IDLE and rr_ptr=0.
- Timeout (MEM_ARB_TIMEOUT_EN, TIMEOUT=10):
  - No mem_ready for 10 ISSUE cycles -> arb_err pulses once, no cN_ready, mem_read drops.
  - Without the macro, same stimulus -> mem_read stays high and arb_err stays 0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_pkg
// Brief    : Shared types and constants for the two-client memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    localparam int unsigned ADDR_W_DEF = 28;
    localparam int unsigned DATA_W_DEF = 128;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2
    } arb_state_t;

    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter_if
// Brief    : Level-handshake block memory bus (read/write held until ready).
// Revision : 1.0 - initial release
// ============================================================================
interface mem_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
);
    logic              read;
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              ready;

    modport master (output read, write, addr, wdata, input rdata, ready);
    modport slave  (input read, write, addr, wdata, output rdata, ready);
endinterface
`default_nettype wire

// File: rtl/mem_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb2
// Brief    : Combinational two-way round-robin select; rr_ptr wins a tie.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arb2 (
    input  wire logic [1:0] req,
    input  wire logic       rr_ptr,
    output logic            gnt_id,
    output logic            gnt_valid
);
    assign gnt_valid = |req;
    assign gnt_id    = (&req) ? rr_ptr : req[1];
endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Brief    : Round-robin arbiter of I-cache (c0) and D-cache (c1) onto one
//            block memory port. Define MEM_ARB_TIMEOUT_EN for the watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned TIMEOUT = 255
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    mem_arbiter_if.slave  c0,
    mem_arbiter_if.slave  c1,
    mem_arbiter_if.master mem,
    output logic          arb_err
);
    arb_state_t        r_state;
    logic              r_rr_ptr;
    logic              r_grant;
    logic              r_mem_read;
    logic              r_mem_write;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;

    logic [1:0]        w_req;
    logic              w_gnt_id;
    logic              w_gnt_valid;
    logic              w_sel_op;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;
    logic              w_timeout;

    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("mem_arbiter: TIMEOUT must be at least 1");
    end

    assign w_req = {c1.read | c1.write, c0.read | c0.write};

    rr_arb2 u_rr_arb2 (
        .req       (w_req),
        .rr_ptr    (r_rr_ptr),
        .gnt_id    (w_gnt_id),
        .gnt_valid (w_gnt_valid)
    );

    // Write wins when a client illegally raises read and write together.
    assign w_sel_op    = w_gnt_id ? (c1.write ? OP_WRITE : OP_READ)
                                  : (c0.write ? OP_WRITE : OP_READ);
    assign w_sel_addr  = w_gnt_id ? c1.addr  : c0.addr;
    assign w_sel_wdata = w_gnt_id ? c1.wdata : c0.wdata;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = ($clog2(TIMEOUT + 1) < 8) ? 8 : $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_arb_err;

    assign w_timeout = (r_state == ST_ISSUE) && (r_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_arb_err <= 1'b0;
        end else begin
            r_arb_err <= w_timeout && !mem.ready;
            if (r_state == ST_IDLE) begin
                r_cnt <= '0;
            end else if (r_state == ST_ISSUE) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign arb_err = r_arb_err;
`else
    assign w_timeout = 1'b0;
    assign arb_err   = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_rr_ptr    <= 1'b0;
            r_grant     <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_gnt_valid) begin
                        r_grant     <= w_gnt_id;
                        r_mem_read  <= (w_sel_op == OP_READ);
                        r_mem_write <= (w_sel_op == OP_WRITE);
                        r_mem_addr  <= w_sel_addr;
                        r_mem_wdata <= w_sel_wdata;
                        r_state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (mem.ready || w_timeout) begin
                        r_mem_read  <= 1'b0;
                        r_mem_write <= 1'b0;
                        r_rr_ptr    <= ~r_grant;
                        r_state     <= ST_DONE;
                    end
                end
                // Swallows the request the caches still hold one cycle past ready.
                ST_DONE:  r_state <= ST_IDLE;
                default:  r_state <= ST_IDLE;
            endcase
        end
    end

    assign mem.read  = r_mem_read;
    assign mem.write = r_mem_write;
    assign mem.addr  = r_mem_addr;
    assign mem.wdata = r_mem_wdata;

    assign c0.ready = mem.ready && (r_state == ST_ISSUE) && (r_grant == 1'b0);
    assign c1.ready = mem.ready && (r_state == ST_ISSUE) && (r_grant == 1'b1);
    assign c0.rdata = mem.rdata;
    assign c1.rdata = mem.rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Brief    : Scoreboard bench for mem_arbiter with a latency-driven memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;
    localparam int unsigned ADDR_W  = 28;
    localparam int unsigned DATA_W  = 128;
    localparam int unsigned TIMEOUT = 10;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic arb_err;

    mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) c0_if ();
    mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) c1_if ();
    mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mem_if ();

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .c0      (c0_if),
        .c1      (c1_if),
        .mem     (mem_if),
        .arb_err (arb_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    endtask

    typedef struct { logic wr; logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] wdata; } mem_exp_t;
    typedef struct { int id; logic chk; logic [DATA_W-1:0] rdata; } rsp_exp_t;
    mem_exp_t mem_q[$];
    rsp_exp_t rsp_q[$];

    function automatic logic [DATA_W-1:0] rdata_for(input logic [ADDR_W-1:0] a);
        return {32'hDEADBEEF, 32'hCAFEF00D, 36'h0, a};
    endfunction

    function automatic mem_exp_t mk_mem(input logic wr, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        mem_exp_t e;
        e.wr = wr; e.addr = a; e.wdata = d;
        return e;
    endfunction

    function automatic rsp_exp_t mk_rsp(input int id, input logic chk, input logic [DATA_W-1:0] d);
        rsp_exp_t e;
        e.id = id; e.chk = chk; e.rdata = d;
        return e;
    endfunction

    // Memory model: pulse ready after resp_lat cycles of a visible request.
    bit resp_en  = 1'b1;
    int resp_lat = 5;
    int resp_cnt = 0;
    initial begin
        mem_if.ready = 1'b0;
        mem_if.rdata = '0;
        forever begin
            @(posedge clk); #1;
            mem_if.ready = 1'b0;
            if (rst_n && resp_en && (mem_if.read || mem_if.write)) begin
                resp_cnt++;
                if (resp_cnt == resp_lat) begin
                    mem_if.ready = 1'b1;
                    mem_if.rdata = rdata_for(mem_if.addr);
                    resp_cnt     = 0;
                end
            end else begin
                resp_cnt = 0;
            end
        end
    end

    // Monitor: pops expectations when the DUT starts a request or signals ready.
    int   cyc = 0;
    int   last_ready_cyc = -100;
    logic prev_req = 1'b0;
    logic prev_ready = 1'b0;
    initial begin
        logic     req;
        mem_exp_t me;
        rsp_exp_t re;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                prev_req   = 1'b0;
                prev_ready = 1'b0;
                continue;
            end
            req = mem_if.read | mem_if.write;
            if (req && !prev_req) begin
                check("grant_gap_after_ready", ((cyc - last_ready_cyc) >= 3), 1'b1);
                if (mem_q.size() == 0) begin
                    check("unexpected_mem_request", 1'b1, 1'b0);
                end else begin
                    me = mem_q.pop_front();
                    check("mem_read_op", mem_if.read, !me.wr);
                    check("mem_write_op", mem_if.write, me.wr);
                    check("mem_addr", mem_if.addr, me.addr);
                    if (me.wr) check("mem_wdata", mem_if.wdata, me.wdata);
                end
            end
            if (prev_ready) check("req_drop_after_ready", req, 1'b0);
            if (c0_if.ready || c1_if.ready) begin
                check("single_client_ready", c0_if.ready & c1_if.ready, 1'b0);
                if (rsp_q.size() == 0) begin
                    check("unexpected_client_ready", 1'b1, 1'b0);
                end else begin
                    re = rsp_q.pop_front();
                    check("ready_client_id", c1_if.ready ? 1 : 0, re.id);
                    if (re.chk)
                        check("client_rdata", (re.id == 1) ? c1_if.rdata : c0_if.rdata, re.rdata);
                end
            end
            if (mem_if.ready) last_ready_cyc = cyc;
            prev_req   = req;
            prev_ready = mem_if.ready;
        end
    end

    task automatic drive(input int id, input logic rd, input logic wr,
                         input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        if (id == 0) begin
            c0_if.read = rd; c0_if.write = wr; c0_if.addr = a; c0_if.wdata = d;
        end else begin
            c1_if.read = rd; c1_if.write = wr; c1_if.addr = a; c1_if.wdata = d;
        end
    endtask

    // Cache-like client: hold until ready, keep request one more cycle, then drop.
    task automatic do_txn(input int id, input logic rd, input logic wr,
                          input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        logic got;
        got = 1'b0;
        drive(id, rd, wr, a, d);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if ((id == 0) ? c0_if.ready : c1_if.ready) begin
                got = 1'b1;
                break;
            end
        end
        check($sformatf("c%0d_ready_seen", id), got, 1'b1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        drive(id, 1'b0, 1'b0, a, d);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic got;
        int   high_cnt;
        int   err_cnt;
        logic [DATA_W-1:0] d1, d2, d3;
        d1 = {4{32'h11111111}};
        d2 = {4{32'h22222222}};
        d3 = {4{32'h33333333}};
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_mem_read", mem_if.read, 1'b0);
        check("rst_mem_write", mem_if.write, 1'b0);
        check("rst_mem_addr", mem_if.addr, '0);
        check("rst_mem_wdata", mem_if.wdata, '0);
        check("rst_arb_err", arb_err, 1'b0);
        check("rst_c0_ready", c0_if.ready, 1'b0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Single read with exact latency
        mem_q.push_back(mk_mem(1'b0, 28'h0000010, '0));
        rsp_q.push_back(mk_rsp(0, 1'b1, rdata_for(28'h0000010)));
        fork
            do_txn(0, 1'b1, 1'b0, 28'h0000010, '0);
            begin
                @(negedge clk); check("t1_read_cycle_n", mem_if.read, 1'b0);
                @(negedge clk); check("t1_read_cycle_n1", mem_if.read, 1'b1);
                check("t1_addr", mem_if.addr, 28'h0000010);
                repeat (4) @(negedge clk);
                check("t1_c0_ready_cycle", c0_if.ready, 1'b1);
                check("t1_c0_rdata", c0_if.rdata, rdata_for(28'h0000010));
                @(negedge clk); check("t1_read_dropped", mem_if.read, 1'b0);
            end
        join

        // Asynchronous reset in the middle of ISSUE
        resp_en = 1'b0;
        mem_q.push_back(mk_mem(1'b0, 28'h0000050, '0));
        drive(0, 1'b1, 1'b0, 28'h0000050, '0);
        got = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (mem_if.read) begin got = 1'b1; break; end
        end
        check("t2_issue_seen", got, 1'b1);
        #2 rst_n = 1'b0;
        #1 check("t2_async_read_drop", mem_if.read, 1'b0);
        drive(0, 1'b0, 1'b0, '0, '0);
        @(posedge clk); #1 rst_n = 1'b1;
        resp_en = 1'b1;
        @(posedge clk); #1;

        // Contention after reset: rr_ptr back at client 0
        mem_q.push_back(mk_mem(1'b0, 28'h0000030, '0));
        mem_q.push_back(mk_mem(1'b1, 28'h0000020, d1));
        rsp_q.push_back(mk_rsp(0, 1'b1, rdata_for(28'h0000030)));
        rsp_q.push_back(mk_rsp(1, 1'b0, '0));
        fork
            do_txn(0, 1'b1, 1'b0, 28'h0000030, '0);
            do_txn(1, 1'b0, 1'b1, 28'h0000020, d1);
        join
        @(posedge clk); #1;

        // Client 0 alone, so the pointer now favours client 1
        mem_q.push_back(mk_mem(1'b0, 28'h0000070, '0));
        rsp_q.push_back(mk_rsp(0, 1'b1, rdata_for(28'h0000070)));
        do_txn(0, 1'b1, 1'b0, 28'h0000070, '0);
        @(posedge clk); #1;

        mem_q.push_back(mk_mem(1'b0, 28'h0000080, '0));
        mem_q.push_back(mk_mem(1'b1, 28'h0000090, d2));
        rsp_q.push_back(mk_rsp(1, 1'b1, rdata_for(28'h0000080)));
        rsp_q.push_back(mk_rsp(0, 1'b0, '0));
        fork
            do_txn(1, 1'b1, 1'b0, 28'h0000080, '0);
            do_txn(0, 1'b0, 1'b1, 28'h0000090, d2);
        join
        @(posedge clk); #1;

        // Illegal read+write: serviced as write
        mem_q.push_back(mk_mem(1'b1, 28'h00000A0, d3));
        rsp_q.push_back(mk_rsp(1, 1'b0, '0));
        do_txn(1, 1'b1, 1'b1, 28'h00000A0, d3);
        @(posedge clk); #1;

        // Memory never answers
        resp_en = 1'b0;
        mem_q.push_back(mk_mem(1'b0, 28'h00000B0, '0));
        drive(1, 1'b1, 1'b0, 28'h00000B0, '0);
        got = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (mem_if.read) begin got = 1'b1; break; end
        end
        check("t7_issue_seen", got, 1'b1);
        high_cnt = 1;
        err_cnt  = 0;
        for (int i = 0; i < 29; i++) begin
            @(negedge clk);
            if (mem_if.read) high_cnt++;
            if (arb_err) begin
                err_cnt++;
                drive(1, 1'b0, 1'b0, '0, '0);
            end
        end
`ifdef MEM_ARB_TIMEOUT_EN
        check("t7_issue_cycles", high_cnt, TIMEOUT);
        check("t7_arb_err_pulses", err_cnt, 1);
        check("t7_read_dropped", mem_if.read, 1'b0);
`else
        check("t7_issue_cycles", high_cnt, 30);
        check("t7_arb_err_pulses", err_cnt, 0);
        check("t7_read_held", mem_if.read, 1'b1);
`endif
        drive(1, 1'b0, 1'b0, '0, '0);
        #2 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        resp_en = 1'b1;
        repeat (3) @(negedge clk);

        check("mem_queue_drained", mem_q.size(), 0);
        check("rsp_queue_drained", rsp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
